// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding word request to instruction memory,
// a single-entry ir register toward execute, PC redirect and halt detection.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OP  = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        discard_q, discard_d;
  logic        halted_q, halted_d;
  logic        new_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      ir_q      <= '0;
      ir_pc_q   <= '0;
      discard_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      ir_pc_q   <= ir_pc_d;
      discard_q <= discard_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    ir_pc_d   = ir_pc_q;
    discard_d = discard_q;
    halted_d  = halted_q;
    new_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (en) begin
          state_d = FETCH;
          new_req = 1'b1;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          discard_d = 1'b0;
          if (redirect) begin
            pc_d    = redirect_pc;
            new_req = 1'b1;
          end else if (discard_q) begin
            // Stale response from before a redirect: drop it and refetch at pc.
            new_req = 1'b1;
          end else if (imem_rdata[31:27] == HALT_OP) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            ir_d    = imem_rdata;
            ir_pc_d = addr_q;
            pc_d    = addr_q + 16'd1;
            state_d = HOLD;
          end
        end else if (redirect) begin
          // The request is already on the bus; keep it stable and mark it stale.
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || ir_ready) begin
          if (redirect) begin
            pc_d = redirect_pc;
          end
          state_d = en ? FETCH : IDLE;
          new_req = en;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (new_req) begin
      addr_d = pc_d;
    end
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = (state_q == HOLD);
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a default-PC instance and a RESET_PC=16'hFFFF instance share stimulus.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, en, imem_ack, ir_ready, redirect;
  logic [31:0] imem_rdata;
  logic [15:0] redirect_pc;
  logic        imem_req, ir_valid, halted;
  logic [15:0] imem_addr, ir_pc;
  logic [31:0] ir;
  logic        d1_imem_req, d1_ir_valid, d1_halted;
  logic [15:0] d1_imem_addr, d1_ir_pc;
  logic [31:0] d1_ir;

  int checks = 0;
  int errors = 0;
  logic [47:0] sb_q[$];
  logic [15:0] last_addr1;
  logic [31:0] a_words [3] = '{32'h100000A0, 32'h100000A1, 32'h100000A2};

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .en(en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .ir_pc(ir_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .imem_req(d1_imem_req), .imem_addr(d1_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(d1_ir), .ir_valid(d1_ir_valid),
    .ir_ready(ir_ready), .ir_pc(d1_ir_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(d1_halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; imem_rdata = '0;
    step();
    step();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_timeout imem_req=%0b required 1", imem_req);
    end
  endtask

  // Memory responder: acks the pending request after lat wait cycles.
  task automatic serve(input logic [31:0] data, input int lat, input logic [15:0] exp_addr,
                       input bit deliver);
    bit ok;
    logic [47:0] e;
    wait_req(ok);
    last_addr1 = d1_imem_addr;
    checks++;
    if (imem_addr !== exp_addr) begin
      errors++;
      $display("FAIL req_addr got %h required %h", imem_addr, exp_addr);
    end
    repeat (lat) begin
      step();
      checks++;
      if (imem_addr !== exp_addr || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL addr_hold got req=%0b addr=%h required req=1 addr=%h", imem_req, imem_addr, exp_addr);
      end
    end
    if (deliver) sb_q.push_back({exp_addr, data});
    imem_ack = 1'b1;
    imem_rdata = data;
    step();
    imem_ack = 1'b0;
    imem_rdata = '0;
    $display("txn addr=%h data=%h deliver=%0b", exp_addr, data, deliver);
    if (deliver) begin
      checks++;
      if (ir_valid !== 1'b1) begin
        errors++;
        $display("FAIL ir_valid_after_ack got %0b required 1", ir_valid);
      end
      e = sb_q.pop_front();
      checks++;
      if (ir !== e[31:0] || ir_pc !== e[47:32]) begin
        errors++;
        $display("FAIL ir_data got ir=%h ir_pc=%h required ir=%h ir_pc=%h", ir, ir_pc, e[31:0], e[47:32]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || ir !== 32'h0 || ir_pc !== 16'h0 ||
        ir_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got req=%0b addr=%h ir=%h ir_pc=%h v=%0b h=%0b required all zero",
               imem_req, imem_addr, ir, ir_pc, ir_valid, halted);
    end
    checks++;
    if (d1_imem_addr !== 16'hFFFF || d1_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap_addr got %h req=%0b required ffff req=0", d1_imem_addr, d1_imem_req);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    en = 1'b1;
    ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) serve(a_words[i], 2, 16'(i), 1'b1);
    en = 1'b0;
    step();
    ir_ready = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL seq_to_idle got v=%0b req=%0b required 0 0", ir_valid, imem_req);
    end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1;
    ir_ready = 1'b0;
    serve(a_words[0], 2, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ir_valid !== 1'b1 || ir !== a_words[0] || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got v=%0b ir=%h req=%0b required 1 %h 0", ir_valid, ir, imem_req, a_words[0]);
      end
    end
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      errors++;
      $display("FAIL stall_release got v=%0b req=%0b addr=%h required 0 1 0001", ir_valid, imem_req, imem_addr);
    end
    en = 1'b0;
    serve(a_words[1], 1, 16'h0001, 1'b1);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL en_low_idle got v=%0b req=%0b required 0 0", ir_valid, imem_req);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    en = 1'b1; redirect = 1'b1; redirect_pc = 16'h0003;
    step();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0003) begin
      errors++;
      $display("FAIL idle_redirect got req=%0b addr=%h required 1 0003", imem_req, imem_addr);
    end
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0003) begin
        errors++;
        $display("FAIL pending_addr_hold got req=%0b addr=%h required 1 0003", imem_req, imem_addr);
      end
      step();
    end
    // Stale ack carries a halt opcode: it must be neither presented nor halt the unit.
    imem_ack = 1'b1; imem_rdata = 32'hF8000000;
    step();
    imem_ack = 1'b0; imem_rdata = '0;
    checks++;
    if (ir_valid !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL discard_ack got v=%0b h=%0b req=%0b addr=%h required 0 0 1 0040",
               ir_valid, halted, imem_req, imem_addr);
    end
    serve(32'h20000040, 1, 16'h0040, 1'b1);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    checks++;
    if (imem_addr !== 16'h0041 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL after_redirect_addr got %h req=%0b required 0041 1", imem_addr, imem_req);
    end
    imem_ack = 1'b1; imem_rdata = 32'hF8000000; redirect = 1'b1; redirect_pc = 16'h0080;
    step();
    imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
      errors++;
      $display("FAIL redirect_with_ack got v=%0b h=%0b req=%0b addr=%h required 0 0 1 0080",
               ir_valid, halted, imem_req, imem_addr);
    end
    serve(32'h20000080, 0, 16'h0080, 1'b1);
    en = 1'b0; redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_redirect got v=%0b req=%0b required 0 0", ir_valid, imem_req);
    end
    en = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL hold_redirect_target got req=%0b addr=%h required 1 0010", imem_req, imem_addr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    en = 1'b1;
    serve(32'hF8000000, 1, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (halted !== 1'b1 || ir_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL halt_state got h=%0b v=%0b req=%0b required 1 0 0", halted, ir_valid, imem_req);
      end
      redirect = 1'b1; redirect_pc = 16'h0010; imem_ack = 1'b1; ir_ready = 1'b1;
      step();
    end
    redirect = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0;
    do_reset();
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_cleared got h=%0b req=%0b required 0 0", halted, imem_req);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1;
    ir_ready = 1'b1;
    serve(32'h30000001, 0, 16'h0000, 1'b1);
    checks++;
    if (last_addr1 !== 16'hFFFF || d1_ir_pc !== 16'hFFFF || d1_ir !== 32'h30000001) begin
      errors++;
      $display("FAIL wrap_first got addr=%h ir_pc=%h ir=%h required ffff ffff 30000001",
               last_addr1, d1_ir_pc, d1_ir);
    end
    serve(32'h30000002, 0, 16'h0001, 1'b1);
    checks++;
    if (last_addr1 !== 16'h0000 || d1_ir_pc !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_second got addr=%h ir_pc=%h required 0000 0000", last_addr1, d1_ir_pc);
    end
    en = 1'b0;
    step();
    ir_ready = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    do_reset();
    en = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_fetch_req got %0b required 1", imem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || ir_valid !== 1'b0 || d1_imem_addr !== 16'hFFFF) begin
      errors++;
      $display("FAIL async_reset got req=%0b addr=%h v=%0b d1addr=%h required 0 0000 0 ffff",
               imem_req, imem_addr, ir_valid, d1_imem_addr);
    end
    step();
    rst = 1'b0; en = 1'b0; imem_ack = 1'b1; imem_rdata = a_words[1];
    step();
    step();
    imem_ack = 1'b0; imem_rdata = '0;
    checks++;
    if (ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 16'h0 || halted !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_ignored got v=%0b ir=%h ir_pc=%h h=%0b req=%0b required all zero",
               ir_valid, ir, ir_pc, halted, imem_req);
    end
    en = 1'b1;
    wait_req(ok);
    checks++;
    if (imem_addr !== 16'h0000 || d1_imem_addr !== 16'hFFFF) begin
      errors++;
      $display("FAIL restart_addr got %h d1=%h required 0000 ffff", imem_addr, d1_imem_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached 200000 required finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
